drt_frame_receiver: RTL and testbench

- Receive-side counterpart of the car direction serializer. It is the far end of the serial/latch/enable direction link.
- Deserializes the 9-period direction frame (four bit/complement pairs, then a latch period), checks each pair and recovers the 4-bit direction word.
- Runs a link watchdog that forces a safe stop code when frames stop arriving.
- Used on the motor-driver side and as the in-system loopback checker for the transmitter.

---
 rtl/drt_frame_receiver_if.sv | 25 ++
 rtl/drt_frame_receiver.sv | 102 ++++++++++
 tb/tb_drt_frame_receiver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/drt_frame_receiver_if.sv
// Direction-link bundle: serial link pins from the transmitter plus the
// recovered direction word and link status toward the motor driver.
interface drt_frame_receiver_if #(
   parameter int ERR_W = 8
);
   logic             ser_clk;
   logic             ser_data;
   logic             ser_latch;
   logic             ser_oe_n;
   logic [3:0]       drt_out;
   logic             drt_valid;
   logic             frame_err;
   logic [ERR_W-1:0] err_cnt;
   logic             link_lost;

   modport master (
      output ser_clk, ser_data, ser_latch, ser_oe_n,
      input  drt_out, drt_valid, frame_err, err_cnt, link_lost
   );

   modport slave (
      input  ser_clk, ser_data, ser_latch, ser_oe_n,
      output drt_out, drt_valid, frame_err, err_cnt, link_lost
   );
endinterface

// File: rtl/drt_frame_receiver.sv
// Deserializes the 9-period direction frame, validates bit/complement pairs
// and runs a watchdog that forces a safe stop when frames stop arriving.
module drt_frame_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1000000,
   parameter int ERR_W       = 8
) (
   input  logic clk,
   input  logic rst,
   drt_frame_receiver_if.slave link
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync, r_lat_sync, r_oe_sync;
   logic                   r_clk_d, r_lat_d;
   logic [7:0]             r_sr;
   logic [3:0]             r_bit_cnt;
   logic [WD_W-1:0]        r_wd;
   logic [3:0]             r_drt;
   logic                   r_valid, r_ferr, r_lost;
   logic [ERR_W-1:0]       r_err_cnt;

   logic w_clk_s, w_dat_s, w_lat_s, w_oe_s;
   logic w_clk_rise, w_lat_rise, w_pairs_ok, w_good;

   assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
   assign w_lat_s    = r_lat_sync[SYNC_STAGES-1];
   assign w_oe_s     = r_oe_sync[SYNC_STAGES-1];
   assign w_clk_rise = w_clk_s & ~r_clk_d;
   assign w_lat_rise = w_lat_s & ~r_lat_d;
   assign w_pairs_ok = (r_sr[7] ^ r_sr[6]) & (r_sr[5] ^ r_sr[4]) &
                       (r_sr[3] ^ r_sr[2]) & (r_sr[1] ^ r_sr[0]);
   assign w_good     = (r_bit_cnt == 4'd8) & w_pairs_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync <= '0;
         r_dat_sync <= '0;
         r_lat_sync <= '0;
         r_oe_sync  <= '0;
         r_clk_d    <= 1'b0;
         r_lat_d    <= 1'b0;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], link.ser_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], link.ser_data};
         r_lat_sync <= {r_lat_sync[SYNC_STAGES-2:0], link.ser_latch};
         r_oe_sync  <= {r_oe_sync[SYNC_STAGES-2:0], link.ser_oe_n};
         r_clk_d    <= w_clk_s;
         r_lat_d    <= w_lat_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr      <= '0;
         r_bit_cnt <= '0;
         r_wd      <= '0;
         r_drt     <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_lost    <= 1'b1;
         r_err_cnt <= '0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         // Latch edge wins over a coincident shift and over watchdog expiry.
         if (w_lat_rise) begin
            r_bit_cnt <= '0;
            r_wd      <= '0;
            if (w_good) begin
               r_drt   <= {r_sr[1], r_sr[3], r_sr[5], r_sr[7]};
               r_valid <= 1'b1;
               r_lost  <= 1'b0;
            end else begin
               r_ferr <= 1'b1;
               if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end
         end else begin
            if (w_clk_rise && !w_lat_s) begin
               r_sr <= {r_sr[6:0], w_dat_s};
               if (r_bit_cnt != 4'd15) r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_wd != WD_MAX) begin
               r_wd <= r_wd + 1'b1;
               if (r_wd == WD_MAX - 1'b1) begin
                  r_lost <= 1'b1;
                  r_drt  <= '0;
               end
            end
         end
      end
   end

   // Output enable only masks the pins; the stored word survives.
   assign link.drt_out   = w_oe_s ? 4'b0000 : r_drt;
   assign link.drt_valid = r_valid;
   assign link.frame_err = r_ferr;
   assign link.err_cnt   = r_err_cnt;
   assign link.link_lost = r_lost;
endmodule

// File: tb/tb_drt_frame_receiver.sv
// Directed bench for the direction-frame receiver: good/bad frames, watchdog,
// output enable, error saturation and mid-frame reset.
module tb_drt_frame_receiver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   both_hi = 0;
   int   nv, ne, lat;

   always #5 clk = ~clk;

   drt_frame_receiver_if #(.ERR_W(2)) link ();

   drt_frame_receiver #(.SYNC_STAGES(2), .TIMEOUT(2000), .ERR_W(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   always @(negedge clk) if (link.drt_valid && link.frame_err) both_hi++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bits leave MSB first; data changes with ser_clk low, 40 clk per period.
   task automatic shift_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         link.ser_clk  = 1'b0;
         link.ser_data = bits[i];
         repeat (20) @(negedge clk);
         link.ser_clk = 1'b1;
         repeat (19) @(negedge clk);
      end
   endtask

   task automatic latch_pulse(output int v, output int e, output int l);
      v = 0; e = 0; l = 0;
      @(negedge clk);
      link.ser_clk   = 1'b0;
      link.ser_latch = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         if (link.drt_valid) v++;
         if (link.frame_err) e++;
         if ((link.drt_valid || link.frame_err) && l == 0) l = i;
         if (i == 20) link.ser_clk = 1'b1;
         if (i == 40) begin
            link.ser_latch = 1'b0;
            link.ser_clk   = 1'b0;
         end
      end
   endtask

   initial begin
      link.ser_clk = 1'b0; link.ser_data = 1'b0;
      link.ser_latch = 1'b0; link.ser_oe_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_drt", 32'(link.drt_out), 32'h0);
      check("rst_valid", 32'(link.drt_valid), 32'h0);
      check("rst_ferr", 32'(link.frame_err), 32'h0);
      check("rst_errcnt", 32'(link.err_cnt), 32'h0);
      check("rst_lost", 32'(link.link_lost), 32'h1);
      rst = 1'b0;

      // Good frame 4'hA
      shift_bits(16'b01100110, 8);
      latch_pulse(nv, ne, lat);
      check("A_drt", 32'(link.drt_out), 32'hA);
      check("A_nvalid", 32'(nv), 32'd1);
      check("A_latency", 32'(lat), 32'd3);
      check("A_lost", 32'(link.link_lost), 32'h0);
      check("A_errcnt", 32'(link.err_cnt), 32'h0);

      // D0=1, ~D0=1
      shift_bits(16'b11100110, 8);
      latch_pulse(nv, ne, lat);
      check("pair_ferr", 32'(ne), 32'd1);
      check("pair_nvalid", 32'(nv), 32'd0);
      check("pair_drt", 32'(link.drt_out), 32'hA);
      check("pair_errcnt", 32'(link.err_cnt), 32'h1);

      shift_bits(16'b1001100, 7);
      latch_pulse(nv, ne, lat);
      check("short_ferr", 32'(ne), 32'd1);
      check("short_errcnt", 32'(link.err_cnt), 32'h2);
      shift_bits(16'b1001100101, 10);
      latch_pulse(nv, ne, lat);
      check("long_ferr", 32'(ne), 32'd1);
      check("long_errcnt", 32'(link.err_cnt), 32'h3);
      shift_bits(16'b10011001, 8);
      latch_pulse(nv, ne, lat);
      check("5_drt", 32'(link.drt_out), 32'h5);
      check("5_nvalid", 32'(nv), 32'd1);

      // Good frame 4'h3, then silence until the watchdog fires
      shift_bits(16'b10100101, 8);
      @(negedge clk);
      link.ser_clk   = 1'b0;
      link.ser_latch = 1'b1;
      for (int i = 1; i <= 2003; i++) begin
         @(negedge clk);
         if (i == 40) link.ser_latch = 1'b0;
         if (i == 3) begin
            check("3_valid", 32'(link.drt_valid), 32'h1);
            check("3_drt", 32'(link.drt_out), 32'h3);
         end
         if (i == 2002) begin
            check("wd_pre_lost", 32'(link.link_lost), 32'h0);
            check("wd_pre_drt", 32'(link.drt_out), 32'h3);
         end
         if (i == 2003) begin
            check("wd_lost", 32'(link.link_lost), 32'h1);
            check("wd_drt", 32'(link.drt_out), 32'h0);
         end
      end
      shift_bits(16'b01101001, 8);
      latch_pulse(nv, ne, lat);
      check("6_drt", 32'(link.drt_out), 32'h6);
      check("6_lost", 32'(link.link_lost), 32'h0);

      // Output enable masks the word without losing it
      link.ser_oe_n = 1'b1;
      repeat (5) @(negedge clk);
      check("oe_drt", 32'(link.drt_out), 32'h0);
      check("oe_lost", 32'(link.link_lost), 32'h0);
      link.ser_oe_n = 1'b0;
      repeat (5) @(negedge clk);
      check("oe_back", 32'(link.drt_out), 32'h6);

      // err_cnt already at 3 (2-bit): must hold
      begin
         int tot = 0;
         for (int k = 0; k < 5; k++) begin
            latch_pulse(nv, ne, lat);
            tot += ne;
         end
         check("sat_nferr", 32'(tot), 32'd5);
         check("sat_errcnt", 32'(link.err_cnt), 32'h3);
      end

      // Async reset after 4 shifts
      shift_bits(16'b1010, 4);
      @(negedge clk);
      link.ser_clk = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_drt", 32'(link.drt_out), 32'h0);
      check("mid_rst_errcnt", 32'(link.err_cnt), 32'h0);
      check("mid_rst_lost", 32'(link.link_lost), 32'h1);
      check("mid_rst_valid", 32'(link.drt_valid), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      latch_pulse(nv, ne, lat);
      check("post_rst_ferr", 32'(ne), 32'd1);
      check("post_rst_lost", 32'(link.link_lost), 32'h1);
      check("post_rst_errcnt", 32'(link.err_cnt), 32'h1);

      check("never_both", 32'(both_hi), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
